mem_initiator: RTL

MEM_INITIATOR -- requirements
Module: mem_initiator

---
 rtl/mem_initiator_if.sv | 22 ++
 rtl/mem_initiator.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_initiator_if.sv
// Request/response bus between the memory initiator and a registered memory responder.
interface mem_initiator_if #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned ADDR_WIDTH = 3
);
    logic                  m_valid;
    logic                  m_wr_rd;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [WIDTH-1:0]      m_wdata;
    logic [WIDTH-1:0]      m_rdata;
    logic                  m_ready;

    modport master (
        output m_valid, m_wr_rd, m_addr, m_wdata,
        input  m_rdata, m_ready
    );

    modport slave (
        input  m_valid, m_wr_rd, m_addr, m_wdata,
        output m_rdata, m_ready
    );
endinterface

// File: rtl/mem_initiator.sv
// Memory sweep engine: fills a memory with seed+idx, reads it back and counts mismatches,
// with a per-transaction ready timeout.
module mem_initiator #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [WIDTH-1:0]      seed,
    mem_initiator_if.master       m,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH:0]   err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic                  timeout
);

    localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StWrite, StWgap, StRead, StRgap, StDone} state_e;

    state_e                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [WIDTH-1:0]      seed_q, seed_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [WaitW-1:0]      wait_q, wait_d;
    logic                  valid_q, valid_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [ADDR_WIDTH:0]   err_q, err_d;
    logic [ADDR_WIDTH-1:0] first_q, first_d;
    logic                  to_q, to_d;

    logic                  finish;
    logic                  last;
    logic [ADDR_WIDTH-1:0] idx_next;
    logic [WIDTH-1:0]      pat_cur;

    assign last     = (idx_q == ADDR_WIDTH'(DEPTH - 1));
    assign idx_next = idx_q + ADDR_WIDTH'(1);
    assign pat_cur  = seed_q + WIDTH'(idx_q);

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= StIdle;
            mode_q  <= '0;
            seed_q  <= '0;
            idx_q   <= '0;
            wait_q  <= '0;
            valid_q <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            first_q <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            seed_q  <= seed_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            valid_q <= valid_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            first_q <= first_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        seed_d  = seed_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        valid_d = valid_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        first_d = first_q;
        to_d    = to_q;
        finish  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && mode != 2'd3) begin
                    mode_d  = mode;
                    seed_d  = seed;
                    idx_d   = '0;
                    wait_d  = '0;
                    err_d   = '0;
                    first_d = '0;
                    to_d    = 1'b0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    addr_d  = '0;
                    if (mode == 2'd1) begin
                        state_d = StRead;
                        wr_d    = 1'b0;
                    end else begin
                        state_d = StWrite;
                        wr_d    = 1'b1;
                        wdata_d = seed;
                    end
                end
            end
            StWrite, StRead: begin
                if (m.m_ready) begin
                    valid_d = 1'b0;
                    if (state_q == StWrite) begin
                        state_d = StWgap;
                    end else begin
                        state_d = StRgap;
                        if (m.m_rdata != pat_cur) begin
                            if (err_q == '0) first_d = idx_q;
                            if (err_q != (ADDR_WIDTH + 1)'(DEPTH)) err_d = err_q + 1'b1;
                        end
                    end
                end else if (wait_q == WaitW'(TIMEOUT - 1)) begin
                    to_d   = 1'b1;
                    finish = 1'b1;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StWgap: begin
                // The gap cycle lets the responder's registered ready fall before the next request.
                if (last) begin
                    idx_d = '0;
                    if (mode_q == 2'd2) begin
                        state_d = StRead;
                        valid_d = 1'b1;
                        wr_d    = 1'b0;
                        addr_d  = '0;
                        wait_d  = '0;
                    end else begin
                        finish = 1'b1;
                    end
                end else begin
                    idx_d   = idx_next;
                    state_d = StWrite;
                    valid_d = 1'b1;
                    wr_d    = 1'b1;
                    addr_d  = idx_next;
                    wdata_d = seed_q + WIDTH'(idx_next);
                    wait_d  = '0;
                end
            end
            StRgap: begin
                if (last) begin
                    finish = 1'b1;
                end else begin
                    idx_d   = idx_next;
                    state_d = StRead;
                    valid_d = 1'b1;
                    addr_d  = idx_next;
                    wait_d  = '0;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (finish) begin
            state_d = StDone;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0) && !to_d;
        end
    end

    assign m.m_valid      = valid_q;
    assign m.m_wr_rd      = wr_q;
    assign m.m_addr       = addr_q;
    assign m.m_wdata      = wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = first_q;
    assign timeout        = to_q;

endmodule
